pipeline_exec_controller: RTL and testbench
===========================================

// Module: pipeline_exec_controller
// PURPOSE
//   Run/step/halt sequencer for the 5-stage MIPS pipeline. Takes run, step and program-reset commands from the debug side
//   and drives the global pipeline-register enable, PC fetch enable, IF/ID flush and program reset.
//   Reacts to the decode-stage Halt flag: freezes fetch, drains older instructions to WB, then parks in HALTED.
//   Counts executed pipeline cycles for the debug readout.
// PARAMETERS
//   PIPE_DEPTH  5   pipeline stages IF..WB (>=3); drain length = PIPE_DEPTH-2 cycles
//   CYC_W       32  width of cycle_cnt
// PORTS
//   clk        in   1      system clock; single clock domain
//   rst_n      in   1      asynchronous, active-low reset
//   cmd_valid  in   1      command present
//   cmd_op     in   2      00 NOP, 01 RUN, 10 STEP, 11 PROG_RESET
//   cmd_ready  out  1      command accepted on the cycle where cmd_valid && cmd_ready
//   halt_id    in   1      Halt flag of the instruction currently in ID (from decode control)
//   pipe_en    out  1      enable for all pipeline registers
//   fetch_en   out  1      PC / IF advance enable
//   flush_if   out  1      load NOP into IF/ID on this edge
//   prog_rst   out  1      synchronous clear of PC and pipeline registers
//   done       out  1      one-cycle pulse when a command completes
//   state      out  3      current FSM state encoding
//   cycle_cnt  out  CYC_W  count of cycles with pipe_en=1
// BEHAVIOUR
//   - States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4, PRST=5. Encodings 6-7 go to IDLE on the next edge.
//   - Reset (async, rst_n=0):
//     - state=IDLE, cycle_cnt=0, drain counter=0.
//     - pipe_en, fetch_en, flush_if, prog_rst and done all 0; cmd_ready=1.
//     - Takes effect immediately in any state, including mid-DRAIN.
//   - Output decode: outputs are combinational from the state register plus halt_id (RUN/STEP only). done is registered.
//   - cmd_ready=1 only in IDLE and HALTED. It is 0 in RUN, STEP, DRAIN and PRST, so commands stall there and are never dropped.
//   - IDLE: all enables 0.
//     - RUN accepted -> RUN.
//     - STEP accepted -> STEP.
//     - PROG_RESET accepted -> PRST.
//     - NOP is accepted and causes no change.
//   - RUN: pipe_en=1, fetch_en=1 every cycle.
//     - If halt_id=1: fetch_en=0 and flush_if=1 in that same cycle (PC frozen, IF/ID gets NOP).
//     - Also load drain counter=PIPE_DEPTH-2 and go to DRAIN.
//   - STEP: exactly one cycle with pipe_en=1, fetch_en=1, then go to IDLE with done=1 on the following cycle.
//     - If halt_id=1 in that cycle, handle it as in RUN: go to DRAIN instead of IDLE, and give no done pulse for the step.
//   - DRAIN: pipe_en=1, fetch_en=0, flush_if=1. Drain counter decrements each cycle.
//     - On the cycle the counter is 1, go to HALTED; done=1 on entry to HALTED.
//   - HALTED: all enables 0.
//     - RUN/STEP are accepted and ignored (state stays 4, no done).
//     - PROG_RESET -> PRST.
//   - PRST: one cycle with prog_rst=1, pipe_en=0, fetch_en=0.
//     - cycle_cnt cleared to 0 at the end of the cycle; then go to IDLE with done=1.
//   - cycle_cnt: +1 on every edge where pipe_en=1. Wraps from 2^CYC_W-1 to 0 with no flag.
//   - Latency:
//     - Command accept -> first pipe_en=1 on the next cycle.
//     - Halt seen in ID -> HALTED after PIPE_DEPTH-2 DRAIN cycles.
//   - Simultaneous: halt_id is ignored outside RUN/STEP. A new command cannot coincide with DRAIN (cmd_ready=0).
// TESTING
//   1. Reset, RUN; halt_id=1 on the 10th RUN cycle -> fetch_en=0 and flush_if=1 that cycle; 3 DRAIN cycles
//      (pipe_en=1, fetch_en=0); then state=4, done pulses once, cycle_cnt=13.
//   2. IDLE, three STEP commands -> exactly three single-cycle pipe_en pulses, three done pulses, cycle_cnt=3,
//      cmd_ready=0 during each STEP cycle.
//   3. HALTED, RUN -> state stays 4, pipe_en=0, no done. Then PROG_RESET -> prog_rst high for 1 cycle,
//      cycle_cnt=0, state=0, done=1.
//   4. cmd_valid=1 with STEP held during RUN -> cmd_ready=0 throughout and no accept until HALTED;
//      the STEP is then accepted and ignored.
//   5. rst_n=0 on the 2nd DRAIN cycle -> state=0 and pipe_en=0 immediately, before the next clk edge; cycle_cnt=0.
//   6. CYC_W=4, RUN for 17 cycles then halt (3 drain) -> cycle_cnt=(17+3) mod 16 = 4.

Source files
------------

// File: rtl/pipeline_exec_controller.sv
// Run/step/halt sequencer for the 5-stage pipeline.
// Drives pipeline enables and counts executed cycles.
module pipeline_exec_controller #(
  parameter int PIPE_DEPTH = 5,
  parameter int CYC_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             halt_id,
  output logic             pipe_en,
  output logic             fetch_en,
  output logic             flush_if,
  output logic             prog_rst,
  output logic             done,
  output logic [2:0]       state,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam int DW = $clog2(PIPE_DEPTH) + 1;

  localparam logic [DW-1:0] DRAIN_LEN =
    DW'(PIPE_DEPTH - 2);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [CYC_W-1:0] C_ONE = CYC_W'(1);

  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_PRST = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4,
    PRST   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          done_d;

  assign state = state_q;

  // state, drain counter and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      done    <= done_d;
    end
  end

  // next-state and output decode
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    done_d    = 1'b0;
    cmd_ready = 1'b0;
    pipe_en   = 1'b0;
    fetch_en  = 1'b0;
    flush_if  = 1'b0;
    prog_rst  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (1'b1)
            (cmd_op == OP_RUN):  state_d = RUN;
            (cmd_op == OP_STEP): state_d = STEP;
            (cmd_op == OP_PRST): state_d = PRST;
            default: ;
          endcase
        end
      end
      RUN: begin
        pipe_en  = 1'b1;
        fetch_en = ~halt_id;
        flush_if = halt_id;
        if (halt_id) begin
          state_d = DRAIN;
          dcnt_d  = DRAIN_LEN;
        end
      end
      STEP: begin
        pipe_en  = 1'b1;
        fetch_en = ~halt_id;
        flush_if = halt_id;
        if (halt_id) begin
          state_d = DRAIN;
          dcnt_d  = DRAIN_LEN;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        pipe_en  = 1'b1;
        flush_if = 1'b1;
        dcnt_d   = dcnt_q - D_ONE;
        if (dcnt_q <= D_ONE) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end
      end
      HALTED: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_op == OP_PRST)
          state_d = PRST;
      end
      PRST: begin
        prog_rst = 1'b1;
        state_d  = IDLE;
        done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // executed-cycle counter, cleared by program reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_cnt <= '0;
    else if (state_q == PRST)
      cycle_cnt <= '0;
    else if (pipe_en)
      cycle_cnt <= cycle_cnt + C_ONE;
  end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for the run/step/halt sequencer.
// Second instance checks counter wrap at CYC_W=4.
module tb_pipeline_exec_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic        halt_id = 1'b0;

  logic        cmd_ready, pipe_en, fetch_en;
  logic        flush_if, prog_rst, done;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;

  logic        cmd_ready4, pipe_en4, fetch_en4;
  logic        flush_if4, prog_rst4, done4;
  logic [2:0]  state4;
  logic [3:0]  cycle_cnt4;

  int n_run = 0;
  int n_fail = 0;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_PRST = 2'b11;

  always #5 clk = ~clk;

  pipeline_exec_controller #(
    .PIPE_DEPTH(5),
    .CYC_W(32)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_ready(cmd_ready),
    .halt_id(halt_id),
    .pipe_en(pipe_en),
    .fetch_en(fetch_en),
    .flush_if(flush_if),
    .prog_rst(prog_rst),
    .done(done),
    .state(state),
    .cycle_cnt(cycle_cnt)
  );

  pipeline_exec_controller #(
    .PIPE_DEPTH(5),
    .CYC_W(4)
  ) u_dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_ready(cmd_ready4),
    .halt_id(halt_id),
    .pipe_en(pipe_en4),
    .fetch_en(fetch_en4),
    .flush_if(flush_if4),
    .prog_rst(prog_rst4),
    .done(done4),
    .state(state4),
    .cycle_cnt(cycle_cnt4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // run n cycles with halt on the last, then 3 drain cycles
  task automatic run_halt(input int n, input string t);
    issue(OP_RUN);
    for (int i = 1; i <= n; i++) begin
      if (i == n) begin
        halt_id = 1'b1;
        #1;
        chk({t, "_halt_fetch"}, 32'(fetch_en), 0);
        chk({t, "_halt_flush"}, 32'(flush_if), 1);
        chk({t, "_halt_pipe"}, 32'(pipe_en), 1);
      end
      tick();
    end
    halt_id = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk({t, "_drain_st"}, 32'(state), 3);
      chk({t, "_drain_pipe"}, 32'(pipe_en), 1);
      chk({t, "_drain_fetch"}, 32'(fetch_en), 0);
      chk({t, "_drain_rdy"}, 32'(cmd_ready), 0);
      chk({t, "_drain_done"}, 32'(done), 0);
      tick();
    end
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_state", 32'(state), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_pipe", 32'(pipe_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", cycle_cnt, 0);
    do_reset();

    // test 1: run, halt on 10th cycle
    chk("t1_ready", 32'(cmd_ready), 1);
    run_halt(10, "t1");
    chk("t1_state", 32'(state), 4);
    chk("t1_done", 32'(done), 1);
    chk("t1_cnt", cycle_cnt, 13);
    tick();
    chk("t1_done_off", 32'(done), 0);

    // test 3: halted ignores run, then prog reset
    issue(OP_RUN);
    chk("t3_state", 32'(state), 4);
    chk("t3_pipe", 32'(pipe_en), 0);
    chk("t3_done", 32'(done), 0);
    issue(OP_PRST);
    chk("t3_prst_st", 32'(state), 5);
    chk("t3_prst", 32'(prog_rst), 1);
    chk("t3_prst_pipe", 32'(pipe_en), 0);
    chk("t3_prst_rdy", 32'(cmd_ready), 0);
    tick();
    chk("t3_idle", 32'(state), 0);
    chk("t3_prst_off", 32'(prog_rst), 0);
    chk("t3_done2", 32'(done), 1);
    chk("t3_cnt", cycle_cnt, 0);

    // test 2: three single steps
    for (int k = 0; k < 3; k++) begin
      issue(OP_STEP);
      chk("t2_st", 32'(state), 2);
      chk("t2_pipe", 32'(pipe_en), 1);
      chk("t2_fetch", 32'(fetch_en), 1);
      chk("t2_rdy", 32'(cmd_ready), 0);
      chk("t2_done0", 32'(done), 0);
      tick();
      chk("t2_idle", 32'(state), 0);
      chk("t2_pipe0", 32'(pipe_en), 0);
      chk("t2_done", 32'(done), 1);
    end
    tick();
    chk("t2_done_off", 32'(done), 0);
    chk("t2_cnt", cycle_cnt, 3);

    // test 4: step held during run stalls until halted
    issue(OP_RUN);
    cmd_valid = 1'b1;
    cmd_op    = OP_STEP;
    for (int i = 1; i <= 5; i++) begin
      chk("t4_rdy_run", 32'(cmd_ready), 0);
      chk("t4_st_run", 32'(state), 1);
      if (i == 5) halt_id = 1'b1;
      tick();
    end
    halt_id = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("t4_rdy_drain", 32'(cmd_ready), 0);
      tick();
    end
    chk("t4_halted", 32'(state), 4);
    chk("t4_rdy_halt", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    chk("t4_stay", 32'(state), 4);
    chk("t4_pipe", 32'(pipe_en), 0);
    chk("t4_nodone", 32'(done), 0);
    chk("t4_cnt", cycle_cnt, 11);

    // test 5: async reset on 2nd drain cycle
    do_reset();
    issue(OP_RUN);
    tick();
    halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    chk("t5_drain1", 32'(state), 3);
    tick();
    chk("t5_drain2", 32'(state), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_state", 32'(state), 0);
    chk("t5_pipe", 32'(pipe_en), 0);
    chk("t5_cnt", cycle_cnt, 0);
    chk("t5_rdy", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // test 6: 17 run + 3 drain wraps 4-bit counter
    run_halt(17, "t6");
    chk("t6_state", 32'(state4), 4);
    chk("t6_cnt4", 32'(cycle_cnt4), 4);
    chk("t6_cnt32", cycle_cnt, 20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
